// File: rtl/reset_seq_pkg.sv
// Shared types and constant helpers for the boot/reset sequencer.
// The timeout math is done here so every instance sizes its timer the same way.
package reset_seq_pkg;

  typedef enum logic [1:0] {
    ST_POR      = 2'd0,
    ST_WAIT_SRC = 2'd1,
    ST_HOLD     = 2'd2,
    ST_RUN      = 2'd3
  } seq_state_t;

  // Last timer value before a timeout-enabled source is bypassed.
  function automatic int calc_tmax(input int clk_hz, input int timeout_ms);
    return clk_hz / 1000 * timeout_ms - 1;
  endfunction

  function automatic int calc_timer_w(input int clk_hz, input int timeout_ms);
    int tmax;
    tmax = calc_tmax(clk_hz, timeout_ms);
    return (tmax < 1) ? 1 : $clog2(tmax + 1);
  endfunction

endpackage

// File: rtl/reset_debounce.sv
// Two-flop synchroniser plus stability counter for the raw user reset button.
// dout follows the synchronised input only after it has differed for CYCLES consecutive cycles.
module reset_debounce #(
  parameter int CYCLES = 320000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic din,
  output logic dout,
  output logic rise
);

  localparam int CW = $clog2(CYCLES + 1);

  logic [1:0]    r_sync;
  logic          r_level;
  logic          r_rise;
  logic [CW-1:0] r_cnt;
  logic          w_differ;
  logic          w_accept;

  assign w_differ = r_sync[1] ^ r_level;
  assign w_accept = w_differ && (r_cnt == CW'(CYCLES - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync  <= '0;
      r_level <= 1'b0;
      r_rise  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync <= {r_sync[0], din};
      // Rise pulses in the same cycle the accepted level first reads high.
      r_rise <= w_accept & r_sync[1];
      if (!w_differ) begin
        r_cnt <= '0;
      end else if (w_accept) begin
        r_cnt   <= '0;
        r_level <= r_sync[1];
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign dout = r_level;
  assign rise = r_rise;

endmodule

// File: rtl/reset_sequencer.sv
// Boot/reset sequencer: waits for readiness sources (or their timeouts), holds reset,
// and handles user/OSD warm resets and cold-boot RAM scrambling.
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int NUM_SRC         = 4,
  parameter int CLK_HZ          = 32000000,
  parameter int TIMEOUT_MS      = 2000,
  parameter int HOLD_CYCLES     = 16,
  parameter int DEBOUNCE_CYCLES = 320000,
  parameter int SCRAMBLE_W      = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [NUM_SRC-1:0]    src_ready,
  input  logic [NUM_SRC-1:0]    src_timeout_en,
  input  logic                  btn_reset,
  input  logic                  osd_reset,
  input  logic                  osd_coldboot,
  output logic                  porb,
  output logic                  resb,
  output logic                  all_ready,
  output logic [NUM_SRC-1:0]    timed_out,
  output logic [SCRAMBLE_W-1:0] ram_scramble,
  output logic [1:0]            state
);

  localparam int TMAX = calc_tmax(CLK_HZ, TIMEOUT_MS);
  localparam int TW   = calc_timer_w(CLK_HZ, TIMEOUT_MS);
  localparam int HW   = $clog2(HOLD_CYCLES + 1);

  seq_state_t            r_state;
  seq_state_t            w_state_nxt;
  logic [HW-1:0]         r_hold_cnt;
  logic [HW-1:0]         w_hold_nxt;
  logic [TW-1:0]         r_timer;
  logic [NUM_SRC-1:0]    r_done;
  logic [NUM_SRC-1:0]    r_timed_out;
  logic                  r_all_ready;
  logic                  r_porb;
  logic [SCRAMBLE_W-1:0] r_scramble;
  logic                  r_cold_d;

  logic                  w_btn_level;
  logic                  w_btn_rise;
  logic                  w_cold_rise;
  logic                  w_req_level;
  logic                  w_hold_last;
  logic                  w_timer_max;
  logic                  w_done_all;
  logic [NUM_SRC-1:0]    w_done_set;

  reset_debounce #(
    .CYCLES (DEBOUNCE_CYCLES)
  ) u_btn_debounce (
    .clk     (clk),
    .reset_n (reset_n),
    .din     (btn_reset),
    .dout    (w_btn_level),
    .rise    (w_btn_rise)
  );

  assign w_cold_rise = osd_coldboot & ~r_cold_d;
  assign w_req_level = w_btn_level | osd_reset;
  assign w_hold_last = (r_hold_cnt == HW'(HOLD_CYCLES - 1));
  assign w_timer_max = (r_timer == TW'(TMAX));
  assign w_done_all  = &r_done;
  // Ready has priority over timeout when both hit in the same cycle.
  assign w_done_set  = src_ready | (src_timeout_en & {NUM_SRC{w_timer_max}});

  always_comb begin
    w_state_nxt = r_state;
    w_hold_nxt  = r_hold_cnt;
    case (r_state)
      ST_POR: begin
        if (w_hold_last) begin
          w_state_nxt = ST_WAIT_SRC;
          w_hold_nxt  = '0;
        end else begin
          w_hold_nxt = r_hold_cnt + 1'b1;
        end
      end
      ST_WAIT_SRC: begin
        if (w_done_all) begin
          w_state_nxt = ST_HOLD;
          w_hold_nxt  = '0;
        end
      end
      ST_HOLD: begin
        if (w_req_level) begin
          w_hold_nxt = '0;
        end else if (w_hold_last) begin
          w_state_nxt = ST_RUN;
          w_hold_nxt  = '0;
        end else begin
          w_hold_nxt = r_hold_cnt + 1'b1;
        end
      end
      ST_RUN: begin
        if (w_btn_rise || osd_reset || w_cold_rise) begin
          w_state_nxt = ST_HOLD;
          w_hold_nxt  = '0;
        end
      end
      default: begin
        w_state_nxt = ST_POR;
        w_hold_nxt  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ST_POR;
      r_hold_cnt  <= '0;
      r_timer     <= '0;
      r_done      <= '0;
      r_timed_out <= '0;
      r_all_ready <= 1'b0;
      r_porb      <= 1'b0;
      r_scramble  <= '0;
      r_cold_d    <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_hold_cnt <= w_hold_nxt;
      r_cold_d   <= osd_coldboot;
      if (r_state == ST_POR && w_hold_last) begin
        r_porb <= 1'b1;
      end
      if (r_state == ST_POR) begin
        r_timer <= '0;
      end else if (r_state == ST_WAIT_SRC && !w_timer_max) begin
        r_timer <= r_timer + 1'b1;
      end
      // Done/timed_out only evolve while waiting; afterwards source drops are ignored.
      if (r_state == ST_WAIT_SRC) begin
        r_done      <= r_done | w_done_set;
        r_timed_out <= r_timed_out | (w_done_set & ~r_done & ~src_ready);
        r_all_ready <= w_done_all;
      end
      if (w_cold_rise && r_state != ST_POR) begin
        r_scramble <= r_scramble + 1'b1;
      end
    end
  end

  assign porb         = r_porb;
  assign resb         = (r_state == ST_RUN);
  assign all_ready    = r_all_ready;
  assign timed_out    = r_timed_out;
  assign ram_scramble = r_scramble;
  assign state        = r_state;

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: randomized source timing against an event-time model,
// plus directed button, OSD reset, cold-boot and async-reset scenarios.
module tb_reset_sequencer;

  localparam int NUM_SRC         = 4;
  localparam int CLK_HZ          = 1000;
  localparam int TIMEOUT_MS      = 20;
  localparam int HOLD_CYCLES     = 4;
  localparam int DEBOUNCE_CYCLES = 3;
  localparam int SCRAMBLE_W      = 2;
  localparam int TMAX            = CLK_HZ / 1000 * TIMEOUT_MS - 1;
  // Edge number (counted from reset release) at which a timeout bypass lands.
  localparam int T_TIMEOUT       = HOLD_CYCLES + TMAX + 1;
  localparam int NEVER           = 100000;

  logic                  clk;
  logic                  reset_n;
  logic [NUM_SRC-1:0]    src_ready;
  logic [NUM_SRC-1:0]    src_timeout_en;
  logic                  btn_reset;
  logic                  osd_reset;
  logic                  osd_coldboot;
  logic                  porb;
  logic                  resb;
  logic                  all_ready;
  logic [NUM_SRC-1:0]    timed_out;
  logic [SCRAMBLE_W-1:0] ram_scramble;
  logic [1:0]            state;

  reset_sequencer #(
    .NUM_SRC         (NUM_SRC),
    .CLK_HZ          (CLK_HZ),
    .TIMEOUT_MS      (TIMEOUT_MS),
    .HOLD_CYCLES     (HOLD_CYCLES),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .SCRAMBLE_W      (SCRAMBLE_W)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .src_ready      (src_ready),
    .src_timeout_en (src_timeout_en),
    .btn_reset      (btn_reset),
    .osd_reset      (osd_reset),
    .osd_coldboot   (osd_coldboot),
    .porb           (porb),
    .resb           (resb),
    .all_ready      (all_ready),
    .timed_out      (timed_out),
    .ram_scramble   (ram_scramble),
    .state          (state)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int rdy_at [NUM_SRC];
  int scr_model = 0;
  logic [31:0] exp_q [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic do_reset(input logic [NUM_SRC-1:0] en, input string tag);
    reset_n        = 1'b0;
    src_ready      = '0;
    src_timeout_en = en;
    btn_reset      = 1'b0;
    osd_reset      = 1'b0;
    osd_coldboot   = 1'b0;
    scr_model      = 0;
    #1;
    check({tag, "_rst_outs"},
          32'({porb, resb, all_ready, timed_out, ram_scramble, state}), 32'd0);
    repeat (2) step();
    reset_n = 1'b1;
  endtask

  // Event-time model: each source is done at its first visible ready edge or at the
  // timeout edge (if enabled and strictly earlier); resb follows the last one by 1+HOLD.
  task automatic run_src_case(input logic [NUM_SRC-1:0] en, input string tag);
    int d;
    int exp_done;
    logic [NUM_SRC-1:0] exp_to;
    int t_porb;
    int t_all;
    int t_resb;
    int limit;
    exp_done = 0;
    exp_to   = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      d = NEVER;
      if (rdy_at[i] < NEVER) d = (rdy_at[i] + 1 > HOLD_CYCLES + 1) ? rdy_at[i] + 1 : HOLD_CYCLES + 1;
      if (en[i] && T_TIMEOUT < d) begin
        d = T_TIMEOUT;
        exp_to[i] = 1'b1;
      end
      if (d > exp_done) exp_done = d;
    end
    do_reset(en, tag);
    t_porb = -1;
    t_all  = -1;
    t_resb = -1;
    limit  = exp_done + 1 + HOLD_CYCLES + 6;
    for (int cyc = 0; cyc < limit; cyc++) begin
      for (int i = 0; i < NUM_SRC; i++) src_ready[i] = (cyc >= rdy_at[i]);
      step();
      if (porb && t_porb < 0) t_porb = cyc + 1;
      if (all_ready && t_all < 0) t_all = cyc + 1;
      if (resb && t_resb < 0) t_resb = cyc + 1;
    end
    check({tag, "_porb_t"}, t_porb, HOLD_CYCLES);
    check({tag, "_all_ready_t"}, t_all, exp_done + 1);
    check({tag, "_resb_t"}, t_resb, exp_done + 1 + HOLD_CYCLES);
    check({tag, "_timed_out"}, 32'(timed_out), 32'(exp_to));
    check({tag, "_state_run"}, 32'(state), 32'd3);
  endtask

  initial begin
    int n_low;
    int t_low;
    int t_high;
    int t_all;
    logic [NUM_SRC-1:0] en_r;

    reset_n        = 1'b0;
    src_ready      = '0;
    src_timeout_en = '0;
    btn_reset      = 1'b0;
    osd_reset      = 1'b0;
    osd_coldboot   = 1'b0;
    step();

    // All sources ready from the start
    rdy_at = '{0, 0, 0, 0};
    run_src_case(4'b0000, "all_ready");

    // Source 3 bypassed by timeout
    rdy_at = '{0, 0, 0, NEVER};
    run_src_case(4'b1000, "timeout3");
    src_ready = 4'b1111;
    repeat (5) step();
    check("late_ready_timed_out", 32'(timed_out), 32'b1000);
    src_ready = 4'b0000;
    repeat (5) step();
    check("drop_all_ready", 32'(all_ready), 32'd1);
    check("drop_resb", 32'(resb), 32'd1);

    // Boundaries: ready on the timeout edge wins; one edge later loses
    rdy_at = '{3, 0, 7, T_TIMEOUT - 1};
    run_src_case(4'b1000, "tie_ready_wins");
    rdy_at = '{3, 0, 7, T_TIMEOUT};
    run_src_case(4'b1000, "ready_too_late");

    // Randomized source arrival and timeout enables
    for (int n = 0; n < 6; n++) begin
      en_r = 4'($urandom_range(0, 15));
      for (int i = 0; i < NUM_SRC; i++) begin
        if ($urandom_range(0, 3) == 0) begin
          rdy_at[i] = NEVER;
          en_r[i]   = 1'b1;
        end else begin
          rdy_at[i] = $urandom_range(0, 40);
        end
      end
      run_src_case(en_r, $sformatf("rand%0d", n));
    end

    // Non-bypassable source stalls indefinitely
    do_reset(4'b0000, "stall");
    n_low = 0;
    for (int k = 0; k < 1000; k++) begin
      src_ready = 4'b0111;
      step();
      if (resb) n_low++;
    end
    check("stall_resb_high_cycles", n_low, 0);
    check("stall_state", 32'(state), 32'd1);
    check("stall_all_ready", 32'(all_ready), 32'd0);
    t_all  = -1;
    t_high = -1;
    for (int k = 0; k < 12; k++) begin
      src_ready = 4'b1111;
      step();
      if (all_ready && t_all < 0) t_all = k + 1;
      if (resb && t_high < 0) t_high = k + 1;
    end
    check("stall_release_all_ready_t", t_all, 2);
    check("stall_release_resb_t", t_high, 2 + HOLD_CYCLES);

    // Button glitch shorter than the debounce window
    n_low = 0;
    for (int k = 0; k < 15; k++) begin
      btn_reset = (k < 2);
      step();
      if (!resb) n_low++;
    end
    check("btn_glitch_low_cycles", n_low, 0);

    // 10-cycle button press
    t_low  = -1;
    t_high = -1;
    for (int k = 0; k < 40; k++) begin
      btn_reset = (k < 10);
      step();
      if (k + 1 == 2 + DEBOUNCE_CYCLES + 1) check("btn_state_hold", 32'(state), 32'd2);
      if (!resb && t_low < 0) t_low = k + 1;
      if (resb && t_low >= 0 && t_high < 0) t_high = k + 1;
    end
    check("btn_resb_low_t", t_low, 2 + DEBOUNCE_CYCLES + 1);
    check("btn_resb_high_t", t_high, 10 + 2 + DEBOUNCE_CYCLES + HOLD_CYCLES);

    // Four cold-boot pulses: 1, 2, 3 then wrap to 0
    n_low = 0;
    for (int k = 0; k < 100; k++) begin
      osd_coldboot = (k < 80) && ((k % 20) < 2);
      if (k < 80 && (k % 20) == 0) begin
        scr_model = (scr_model + 1) % (1 << SCRAMBLE_W);
        exp_q.push_back(32'(scr_model));
      end
      step();
      if (!resb) n_low++;
      if (k + 1 < 80 && ((k + 1) % 20) == 1) begin
        check("cold_scramble", 32'(ram_scramble), exp_q.pop_front());
        check("cold_state_hold", 32'(state), 32'd2);
      end
      if (k + 1 < 80 && ((k + 1) % 20) == 5) check("cold_resb_back", 32'(resb), 32'd1);
    end
    check("cold_total_low", n_low, 4 * HOLD_CYCLES);
    check("cold_wrap_value", 32'(ram_scramble), 32'd0);

    // Button rise and cold-boot rise together, then a cold-boot edge inside HOLD
    t_low  = -1;
    t_high = -1;
    n_low  = 0;
    for (int k = 0; k < 30; k++) begin
      btn_reset    = (k < 6);
      osd_coldboot = (k == 5) || (k == 6) || (k == 10) || (k == 11);
      if (k == 5 || k == 10) scr_model = (scr_model + 1) % (1 << SCRAMBLE_W);
      step();
      if (!resb) n_low++;
      if (!resb && t_low < 0) t_low = k + 1;
      if (resb && t_low >= 0 && t_high < 0) t_high = k + 1;
    end
    check("simul_resb_low_t", t_low, 6);
    check("simul_resb_high_t", t_high, 15);
    check("simul_low_cycles", n_low, 9);
    check("simul_scramble", 32'(ram_scramble), 32'(scr_model));

    // osd_reset held keeps resb low
    t_high = -1;
    n_low  = 0;
    for (int k = 0; k < 45; k++) begin
      osd_reset = (k < 30);
      step();
      if (!resb) n_low++;
      if (resb && n_low > 0 && t_high < 0) t_high = k + 1;
    end
    check("osd_low_cycles", n_low, 33);
    check("osd_resb_high_t", t_high, 34);

    // Asynchronous reset in the middle of HOLD
    osd_reset = 1'b1;
    repeat (3) step();
    osd_reset = 1'b0;
    check("mid_hold_state", 32'(state), 32'd2);
    check("mid_hold_scramble", 32'(ram_scramble), 32'(scr_model));
    #2;
    reset_n = 1'b0;
    #1;
    check("async_porb", 32'(porb), 32'd0);
    check("async_resb", 32'(resb), 32'd0);
    check("async_all_ready", 32'(all_ready), 32'd0);
    check("async_timed_out", 32'(timed_out), 32'd0);
    check("async_scramble", 32'(ram_scramble), 32'd0);
    check("async_state", 32'(state), 32'd0);
    step();
    rdy_at = '{0, 0, 0, 0};
    run_src_case(4'b0000, "replay");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
